// File: rtl/uart_denetleyici.sv
// Register-mapped UART channel controller: baud divisor, RX/TX gating,
// RX byte FIFO and TX FIFO sequenced to the transmitter over valid/ready.
module uart_denetleyici #(
   parameter int          FIFO_DERINLIK  = 8,
   parameter logic [15:0] BAUD_DIV_RESET = 16'd868
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        istek_gecerli_i,
   input  logic        istek_yaz_i,
   input  logic [2:0]  istek_adres_i,
   input  logic [31:0] istek_veri_i,
   output logic        yanit_gecerli_o,
   output logic [31:0] yanit_veri_o,
   output logic [15:0] baud_div_o,
   input  logic [7:0]  alinan_veri_i,
   input  logic        alinan_gecerli_i,
   output logic [7:0]  gonder_veri_o,
   output logic        gonder_gecerli_o,
   input  logic        gonder_hazir_i
);
   localparam int AW = $clog2(FIFO_DERINLIK);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DOLU = CW'(FIFO_DERINLIK);

   typedef enum logic {BOSTA, GONDER} tx_durum_t;

   tx_durum_t   r_durum, w_durum_sonraki;
   logic [1:0]  r_ctrl;
   logic [15:0] r_baud;
   logic        r_rx_ovf, r_tx_ovf;
   logic        r_yanit_gecerli;
   logic [31:0] r_yanit_veri;
   logic [7:0]  r_gonder_veri;

   logic [7:0]    r_rx_mem [FIFO_DERINLIK];
   logic [AW-1:0] r_rx_rd, r_rx_wr;
   logic [CW-1:0] r_rx_say;
   logic [7:0]    r_tx_mem [FIFO_DERINLIK];
   logic [AW-1:0] r_tx_rd, r_tx_wr;
   logic [CW-1:0] r_tx_say;

   logic        w_yaz, w_oku;
   logic        w_rx_bos, w_rx_dolu, w_tx_bos, w_tx_dolu;
   logic        w_rx_pop, w_rx_ist, w_rx_push, w_rx_ovf_set;
   logic        w_tx_pop, w_tx_ist, w_tx_push, w_tx_ovf_set;
   logic        w_tx_yukle;
   logic [5:0]  w_durum_reg;
   logic [31:0] w_okuma_veri;
   logic        w_unused;

   assign w_unused  = ^istek_veri_i[31:16];
   assign w_yaz     = istek_gecerli_i & istek_yaz_i;
   assign w_oku     = istek_gecerli_i & ~istek_yaz_i;
   assign w_rx_bos  = (r_rx_say == '0);
   assign w_rx_dolu = (r_rx_say == DOLU);
   assign w_tx_bos  = (r_tx_say == '0);
   assign w_tx_dolu = (r_tx_say == DOLU);

   // A same-cycle pop frees a slot, so a push into a full FIFO still lands
   assign w_rx_pop     = w_oku && (istek_adres_i == 3'd2) && !w_rx_bos;
   assign w_rx_ist     = alinan_gecerli_i && r_ctrl[0];
   assign w_rx_push    = w_rx_ist && (!w_rx_dolu || w_rx_pop);
   assign w_rx_ovf_set = w_rx_ist && w_rx_dolu && !w_rx_pop;
   assign w_tx_ist     = w_yaz && (istek_adres_i == 3'd3);
   assign w_tx_push    = w_tx_ist && (!w_tx_dolu || w_tx_pop);
   assign w_tx_ovf_set = w_tx_ist && w_tx_dolu && !w_tx_pop;

   assign w_durum_reg = {r_tx_ovf, r_rx_ovf, w_tx_dolu,
                         w_tx_bos, w_rx_dolu, w_rx_bos};

   always_comb begin
      w_okuma_veri = '0;
      case (istek_adres_i)
         3'd0:    w_okuma_veri = {30'd0, r_ctrl};
         3'd1:    w_okuma_veri = {26'd0, w_durum_reg};
         3'd2:    w_okuma_veri = w_rx_bos ? 32'd0 : {24'd0, r_rx_mem[r_rx_rd]};
         3'd4:    w_okuma_veri = {16'd0, r_baud};
         default: w_okuma_veri = '0;
      endcase
   end

   always_comb begin
      w_durum_sonraki = r_durum;
      w_tx_pop        = 1'b0;
      w_tx_yukle      = 1'b0;
      unique case (r_durum)
         BOSTA: begin
            if (r_ctrl[1] && !w_tx_bos) begin
               w_durum_sonraki = GONDER;
               w_tx_yukle      = 1'b1;
            end
         end
         GONDER: begin
            if (gonder_hazir_i) begin
               w_durum_sonraki = BOSTA;
               w_tx_pop        = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_durum         <= BOSTA;
         r_ctrl          <= '0;
         r_baud          <= BAUD_DIV_RESET;
         r_rx_ovf        <= 1'b0;
         r_tx_ovf        <= 1'b0;
         r_yanit_gecerli <= 1'b0;
         r_yanit_veri    <= '0;
         r_gonder_veri   <= '0;
      end else begin
         r_durum         <= w_durum_sonraki;
         r_yanit_gecerli <= w_oku;
         r_yanit_veri    <= w_oku ? w_okuma_veri : 32'd0;
         if (w_tx_yukle) r_gonder_veri <= r_tx_mem[r_tx_rd];
         if (w_yaz && istek_adres_i == 3'd0) r_ctrl <= istek_veri_i[1:0];
         if (w_yaz && istek_adres_i == 3'd4)
            r_baud <= (istek_veri_i[15:0] < 16'd20) ? 16'd20 : istek_veri_i[15:0];
         // Clear first so a same-cycle overflow wins over W1C
         if (w_yaz && istek_adres_i == 3'd1 && istek_veri_i[4]) r_rx_ovf <= 1'b0;
         if (w_yaz && istek_adres_i == 3'd1 && istek_veri_i[5]) r_tx_ovf <= 1'b0;
         if (w_rx_ovf_set) r_rx_ovf <= 1'b1;
         if (w_tx_ovf_set) r_tx_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < FIFO_DERINLIK; i++) r_rx_mem[i] <= '0;
         r_rx_rd  <= '0;
         r_rx_wr  <= '0;
         r_rx_say <= '0;
      end else begin
         if (w_rx_push) begin
            r_rx_mem[r_rx_wr] <= alinan_veri_i;
            r_rx_wr           <= r_rx_wr + 1'b1;
         end
         if (w_rx_pop) r_rx_rd <= r_rx_rd + 1'b1;
         if (w_rx_push && !w_rx_pop) r_rx_say <= r_rx_say + 1'b1;
         else if (!w_rx_push && w_rx_pop) r_rx_say <= r_rx_say - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < FIFO_DERINLIK; i++) r_tx_mem[i] <= '0;
         r_tx_rd  <= '0;
         r_tx_wr  <= '0;
         r_tx_say <= '0;
      end else begin
         if (w_tx_push) begin
            r_tx_mem[r_tx_wr] <= istek_veri_i[7:0];
            r_tx_wr           <= r_tx_wr + 1'b1;
         end
         if (w_tx_pop) r_tx_rd <= r_tx_rd + 1'b1;
         if (w_tx_push && !w_tx_pop) r_tx_say <= r_tx_say + 1'b1;
         else if (!w_tx_push && w_tx_pop) r_tx_say <= r_tx_say - 1'b1;
      end
   end

   assign yanit_gecerli_o  = r_yanit_gecerli;
   assign yanit_veri_o     = r_yanit_veri;
   assign baud_div_o       = r_baud;
   assign gonder_veri_o    = r_gonder_veri;
   assign gonder_gecerli_o = (r_durum == GONDER);

endmodule

// File: tb/tb_uart_denetleyici.sv
// Bench for uart_denetleyici: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_uart_denetleyici;
   localparam int D = 8;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic        istek_gecerli_i, istek_yaz_i;
   logic [2:0]  istek_adres_i;
   logic [31:0] istek_veri_i;
   logic        yanit_gecerli_o;
   logic [31:0] yanit_veri_o;
   logic [15:0] baud_div_o;
   logic [7:0]  alinan_veri_i;
   logic        alinan_gecerli_i;
   logic [7:0]  gonder_veri_o;
   logic        gonder_gecerli_o;
   logic        gonder_hazir_i;

   uart_denetleyici #(.FIFO_DERINLIK(D), .BAUD_DIV_RESET(16'd868)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .istek_gecerli_i(istek_gecerli_i), .istek_yaz_i(istek_yaz_i),
      .istek_adres_i(istek_adres_i), .istek_veri_i(istek_veri_i),
      .yanit_gecerli_o(yanit_gecerli_o), .yanit_veri_o(yanit_veri_o),
      .baud_div_o(baud_div_o),
      .alinan_veri_i(alinan_veri_i), .alinan_gecerli_i(alinan_gecerli_i),
      .gonder_veri_o(gonder_veri_o), .gonder_gecerli_o(gonder_gecerli_o),
      .gonder_hazir_i(gonder_hazir_i)
   );

   always #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]  rxq[$];
   logic [7:0]  txq[$];
   logic [1:0]  m_ctrl;
   logic [15:0] m_baud;
   logic        m_rx_ovf, m_tx_ovf;
   logic        m_busy;
   logic [7:0]  m_gv;
   logic        m_yv;
   logic [31:0] m_yd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      rxq.delete();
      txq.delete();
      m_ctrl = 2'b00; m_baud = 16'd868;
      m_rx_ovf = 1'b0; m_tx_ovf = 1'b0;
      m_busy = 1'b0; m_gv = 8'h00;
      m_yv = 1'b0; m_yd = 32'd0;
   endtask

   function automatic logic [31:0] m_status();
      return {26'd0, m_tx_ovf, m_rx_ovf, txq.size() == D,
              txq.size() == 0, rxq.size() == D, rxq.size() == 0};
   endfunction

   task automatic model_step();
      logic set_rx, set_tx, txpop;
      logic rd, wr;
      set_rx = 0; set_tx = 0; txpop = 0;
      rd = istek_gecerli_i && !istek_yaz_i;
      wr = istek_gecerli_i && istek_yaz_i;
      m_yv = rd;
      if (rd) begin
         case (istek_adres_i)
            3'd0: m_yd = {30'd0, m_ctrl};
            3'd1: m_yd = m_status();
            3'd2: m_yd = (rxq.size() > 0) ? {24'd0, rxq[0]} : 32'd0;
            3'd4: m_yd = {16'd0, m_baud};
            default: m_yd = 32'd0;
         endcase
      end
      if (m_busy) begin
         if (gonder_hazir_i) begin txpop = 1; m_busy = 0; end
      end else if (m_ctrl[1] && txq.size() > 0) begin
         m_busy = 1; m_gv = txq[0];
      end
      if (rd && istek_adres_i == 3'd2 && rxq.size() > 0) void'(rxq.pop_front());
      if (alinan_gecerli_i && m_ctrl[0]) begin
         if (rxq.size() < D) rxq.push_back(alinan_veri_i);
         else set_rx = 1;
      end
      if (txpop) void'(txq.pop_front());
      if (wr && istek_adres_i == 3'd3) begin
         if (txq.size() < D) txq.push_back(istek_veri_i[7:0]);
         else set_tx = 1;
      end
      if (wr) begin
         case (istek_adres_i)
            3'd0: m_ctrl = istek_veri_i[1:0];
            3'd1: begin
               if (istek_veri_i[4]) m_rx_ovf = 0;
               if (istek_veri_i[5]) m_tx_ovf = 0;
            end
            3'd4: m_baud = (istek_veri_i[15:0] < 16'd20) ? 16'd20 : istek_veri_i[15:0];
            default: ;
         endcase
      end
      if (set_rx) m_rx_ovf = 1;
      if (set_tx) m_tx_ovf = 1;
   endtask

   task automatic compare();
      chk("yanit_gecerli", {31'd0, yanit_gecerli_o}, {31'd0, m_yv});
      if (m_yv) chk("yanit_veri", yanit_veri_o, m_yd);
      chk("baud_div", {16'd0, baud_div_o}, {16'd0, m_baud});
      chk("gonder_gecerli", {31'd0, gonder_gecerli_o}, {31'd0, m_busy});
      if (m_busy) chk("gonder_veri", {24'd0, gonder_veri_o}, {24'd0, m_gv});
   endtask

   task automatic step(input logic v, input logic yz, input logic [2:0] a,
                       input logic [31:0] d, input logic av,
                       input logic [7:0] ab, input logic h);
      @(negedge clk_i);
      compare();
      istek_gecerli_i = v; istek_yaz_i = yz;
      istek_adres_i = a; istek_veri_i = d;
      alinan_gecerli_i = av; alinan_veri_i = ab;
      gonder_hazir_i = h;
      model_step();
   endtask

   task automatic idle();
      step(0, 0, 3'd0, 32'd0, 0, 8'd0, 0);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      step(1, 1, a, d, 0, 8'd0, 0);
   endtask

   task automatic rd_expect(input string nm, input logic [2:0] a, input logic [31:0] exp);
      step(1, 0, a, 32'd0, 0, 8'd0, 0);
      idle();
      chk(nm, yanit_veri_o, exp);
   endtask

   initial begin
      rstn_i = 1'b0;
      istek_gecerli_i = 0; istek_yaz_i = 0; istek_adres_i = 0;
      istek_veri_i = 0; alinan_gecerli_i = 0; alinan_veri_i = 0;
      gonder_hazir_i = 0;
      model_reset();
      repeat (2) @(negedge clk_i);
      rstn_i = 1'b1;
      chk("rst_yanit_gecerli", {31'd0, yanit_gecerli_o}, 32'd0);
      chk("rst_yanit_veri", yanit_veri_o, 32'd0);
      chk("rst_baud", {16'd0, baud_div_o}, 32'd868);
      chk("rst_gonder_gecerli", {31'd0, gonder_gecerli_o}, 32'd0);
      chk("rst_gonder_veri", {24'd0, gonder_veri_o}, 32'd0);

      rd_expect("baud_reset", 3'd4, 32'd868);
      wr(3'd4, 32'd5);
      rd_expect("baud_min", 3'd4, 32'd20);
      wr(3'd4, 32'd434);
      idle();
      chk("baud_434", {16'd0, baud_div_o}, 32'd434);

      wr(3'd0, 32'd1);
      step(0, 0, 3'd0, 32'd0, 1, 8'hA5, 0);
      step(0, 0, 3'd0, 32'd0, 1, 8'h3C, 0);
      rd_expect("rx_not_empty", 3'd1, 32'h04);
      rd_expect("rx_a5", 3'd2, 32'hA5);
      rd_expect("rx_3c", 3'd2, 32'h3C);
      rd_expect("rx_empty_again", 3'd1, 32'h05);
      rd_expect("rx_empty_read", 3'd2, 32'h00);

      for (int i = 0; i < 9; i++) step(0, 0, 3'd0, 32'd0, 1, 8'(8'h40 + i), 0);
      rd_expect("rx_full_ovf", 3'd1, 32'h16);
      wr(3'd1, 32'h10);
      rd_expect("rx_ovf_w1c", 3'd1, 32'h06);

      step(1, 0, 3'd2, 32'd0, 1, 8'h77, 0);
      idle();
      chk("rx_pop_push_head", yanit_veri_o, 32'h40);
      rd_expect("rx_pop_push_status", 3'd1, 32'h06);
      for (int i = 1; i < 8; i++) rd_expect("rx_drain", 3'd2, 32'(8'h40 + i));
      rd_expect("rx_last_77", 3'd2, 32'h77);

      wr(3'd0, 32'd2);
      wr(3'd3, 32'h11);
      wr(3'd3, 32'h22);
      idle(); idle();
      chk("tx_valid_11", {31'd0, gonder_gecerli_o}, 32'd1);
      chk("tx_data_11", {24'd0, gonder_veri_o}, 32'h11);
      idle();
      chk("tx_hold_11", {24'd0, gonder_veri_o}, 32'h11);
      step(0, 0, 3'd0, 32'd0, 0, 8'd0, 1);
      idle();
      chk("tx_gap", {31'd0, gonder_gecerli_o}, 32'd0);
      idle();
      chk("tx_valid_22", {31'd0, gonder_gecerli_o}, 32'd1);
      chk("tx_data_22", {24'd0, gonder_veri_o}, 32'h22);
      step(0, 0, 3'd0, 32'd0, 0, 8'd0, 1);
      idle();
      rd_expect("tx_empty", 3'd1, 32'h05);

      wr(3'd3, 32'hA1);
      wr(3'd3, 32'hA2);
      wr(3'd3, 32'hA3);
      idle(); idle();
      chk("tx_busy_pre_rst", {31'd0, gonder_gecerli_o}, 32'd1);
      #3 rstn_i = 1'b0;
      #1 chk("rst_async_gonder", {31'd0, gonder_gecerli_o}, 32'd0);
      chk("rst_async_yanit", {31'd0, yanit_gecerli_o}, 32'd0);
      model_reset();
      @(negedge clk_i);
      rstn_i = 1'b1;
      rd_expect("rst_tx_empty", 3'd1, 32'h05);
      rd_expect("rst_ctrl", 3'd0, 32'h0);

      for (int ph = 0; ph < 2; ph++) begin
         for (int n = 0; n < 1500; n++) begin
            logic v, yz, av, h;
            logic [2:0] a;
            logic [31:0] d;
            v  = 1'($urandom_range(0, 1));
            yz = 1'($urandom_range(0, 1));
            a  = 3'($urandom_range(0, 7));
            d  = $urandom;
            if (a == 3'd4 && $urandom_range(0, 3) == 0) d = $urandom_range(0, 31);
            if (ph == 1 && $urandom_range(0, 2) == 0) begin
               v = 1; yz = 1; a = 3'd3;
            end
            av = ($urandom_range(0, 2) == 0);
            h  = (ph == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
            step(v, yz, a, d, av, 8'($urandom), h);
         end
      end
      idle();
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
